// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: register-file memory, one-entry back-pressurable response stage, side load port.
// Define INST_MEM_FWD_EN to forward same-edge load data to a colliding fetch.
module inst_mem_responder #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              resp_ready,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [CNT_W-1:0]  fetch_cnt
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;

  logic              accept;
  logic              req_in_range;
  logic              ld_in_range;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] fetch_data;

  assign req_ready    = reset && (!resp_valid_q || resp_ready);
  assign accept       = req_valid && req_ready;
  assign req_in_range = {1'b0, req_addr} < DEPTH_L;
  assign ld_in_range  = {1'b0, ld_addr} < DEPTH_L;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req_addr == ADDR_W'(i)) rd_data = mem_q[i];
    end
  end

`ifdef INST_MEM_FWD_EN
  assign fetch_data = (ld_en && ld_in_range && (ld_addr == req_addr)) ? ld_data : rd_data;
`else
  assign fetch_data = rd_data;
`endif

  always_comb begin
    mem_d = mem_q;
    if (ld_en && ld_in_range) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ld_addr == ADDR_W'(i)) mem_d[i] = ld_data;
      end
    end
  end

  // Data and error hold after consumption; only valid drops.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    fetch_cnt_d  = fetch_cnt_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_data_d  = req_in_range ? fetch_data : '0;
      resp_err_d   = !req_in_range;
      fetch_cnt_d  = fetch_cnt_q + CNT_W'(1);
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q        <= '{default: '0};
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      mem_q        <= mem_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: instance a uses defaults, instance b uses DEPTH=3, CNT_W=4.
// Both share stimulus; each is checked against an array-based reference model.
module tb_inst_mem_responder;

`ifdef INST_MEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_addr;
  logic       resp_ready;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;

  logic        req_ready_a, resp_valid_a, resp_err_a;
  logic [7:0]  resp_data_a;
  logic [15:0] fetch_cnt_a;
  logic        req_ready_b, resp_valid_b, resp_err_b;
  logic [7:0]  resp_data_b;
  logic [3:0]  fetch_cnt_b;

  inst_mem_responder u_dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready_a), .resp_valid(resp_valid_a), .resp_data(resp_data_a),
    .resp_err(resp_err_a), .resp_ready(resp_ready), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(fetch_cnt_a)
  );

  inst_mem_responder #(.ADDR_W(2), .DATA_W(8), .DEPTH(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready_b), .resp_valid(resp_valid_b), .resp_data(resp_data_b),
    .resp_err(resp_err_b), .resp_ready(resp_ready), .ld_en(ld_en),
    .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(fetch_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = instance a, 1 = instance b.
  int m_mem [2][4];
  bit m_v   [2];
  int m_d   [2];
  bit m_e   [2];
  int m_c   [2];
  bit m_rst;

  function automatic int dep(input int k); return (k == 0) ? 4 : 3; endfunction
  function automatic int cw(input int k);  return (k == 0) ? 16 : 4; endfunction

  function automatic void model_clear();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_d[k] = 0; m_e[k] = 0; m_c[k] = 0;
      for (int j = 0; j < 4; j++) m_mem[k][j] = 0;
    end
  endfunction

  function automatic bit model_ready(input int k);
    return m_rst && (!m_v[k] || resp_ready);
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      bit rdy;
      rdy = model_ready(k);
      if (req_valid && rdy) begin
        m_v[k] = 1;
        if (int'(req_addr) < dep(k)) begin
          m_e[k] = 0;
          if (FWD && ld_en && ld_addr == req_addr) m_d[k] = int'(ld_data);
          else m_d[k] = m_mem[k][req_addr];
        end else begin
          m_e[k] = 1;
          m_d[k] = 0;
        end
        m_c[k] = (m_c[k] + 1) % (1 << cw(k));
      end else if (m_v[k] && resp_ready) begin
        m_v[k] = 0;
      end
      if (ld_en && int'(ld_addr) < dep(k)) m_mem[k][ld_addr] = int'(ld_data);
    end
  endfunction

  logic rdy_a_pre;

  // Inputs must already be driven; checks ready pre-edge and outputs 1 ns after the edge.
  task automatic cycle();
    #1;
    rdy_a_pre = req_ready_a;
    chk("req_ready_a", req_ready_a, model_ready(0));
    chk("req_ready_b", req_ready_b, model_ready(1));
    @(posedge clk);
    model_edge();
    #1;
    chk("resp_valid_a", resp_valid_a, m_v[0]);
    chk("resp_data_a",  resp_data_a,  m_d[0]);
    chk("resp_err_a",   resp_err_a,   m_e[0]);
    chk("fetch_cnt_a",  fetch_cnt_a,  m_c[0]);
    chk("resp_valid_b", resp_valid_b, m_v[1]);
    chk("resp_data_b",  resp_data_b,  m_d[1]);
    chk("resp_err_b",   resp_err_b,   m_e[1]);
    chk("fetch_cnt_b",  fetch_cnt_b,  m_c[1]);
  endtask

  task automatic drive(input bit rv, input int ra, input bit rr, input bit le, input int la, input int ldv);
    req_valid  = rv;
    req_addr   = 2'(ra);
    resp_ready = rr;
    ld_en      = le;
    ld_addr    = 2'(la);
    ld_data    = 8'(ldv);
  endtask

  typedef struct {
    bit rv; int ra; bit rr; bit le; int la; int ldv;
    bit e_rdy; bit e_v; int e_d; bit e_e; int e_c;
  } vec_t;

  function automatic vec_t v(input bit rv, input int ra, input bit rr, input bit le, input int la,
                             input int ldv, input bit e_rdy, input bit e_v, input int e_d,
                             input bit e_e, input int e_c);
    vec_t t;
    t.rv = rv; t.ra = ra; t.rr = rr; t.le = le; t.la = la; t.ldv = ldv;
    t.e_rdy = e_rdy; t.e_v = e_v; t.e_d = e_d; t.e_e = e_e; t.e_c = e_c;
    return t;
  endfunction

  vec_t tbl [17];
  int   coll;

  initial begin
    coll = FWD ? 'hA5 : 'h33;
    tbl[0]  = v(0, 0, 1, 1, 0, 'h11, 1, 0, 0,     0, 0);
    tbl[1]  = v(0, 0, 1, 1, 1, 'h22, 1, 0, 0,     0, 0);
    tbl[2]  = v(0, 0, 1, 1, 2, 'h33, 1, 0, 0,     0, 0);
    tbl[3]  = v(0, 0, 1, 1, 3, 'h44, 1, 0, 0,     0, 0);
    tbl[4]  = v(1, 0, 1, 0, 0, 0,    1, 1, 'h11,  0, 1);
    tbl[5]  = v(1, 1, 1, 0, 0, 0,    1, 1, 'h22,  0, 2);
    tbl[6]  = v(1, 2, 1, 0, 0, 0,    1, 1, 'h33,  0, 3);
    tbl[7]  = v(1, 3, 1, 0, 0, 0,    1, 1, 'h44,  0, 4);
    tbl[8]  = v(1, 1, 1, 0, 0, 0,    1, 1, 'h22,  0, 5);
    tbl[9]  = v(1, 2, 0, 0, 0, 0,    0, 1, 'h22,  0, 5);
    tbl[10] = v(1, 2, 0, 0, 0, 0,    0, 1, 'h22,  0, 5);
    tbl[11] = v(1, 2, 0, 0, 0, 0,    0, 1, 'h22,  0, 5);
    tbl[12] = v(1, 2, 1, 0, 0, 0,    1, 1, 'h33,  0, 6);
    tbl[13] = v(1, 2, 1, 1, 2, 'hA5, 1, 1, coll,  0, 7);
    tbl[14] = v(1, 2, 1, 0, 0, 0,    1, 1, 'hA5,  0, 8);
    tbl[15] = v(1, 3, 1, 0, 0, 0,    1, 1, 'h44,  0, 9);
    tbl[16] = v(0, 0, 1, 0, 0, 0,    1, 0, 'h44,  0, 9);

    reset = 1'b0;
    m_rst = 1'b0;
    model_clear();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("rst_req_ready",  req_ready_a,  0);
    chk("rst_resp_valid", resp_valid_a, 0);
    chk("rst_resp_data",  resp_data_a,  0);
    chk("rst_resp_err",   resp_err_a,   0);
    chk("rst_fetch_cnt",  fetch_cnt_a,  0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_rst = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rv, tbl[i].ra, tbl[i].rr, tbl[i].le, tbl[i].la, tbl[i].ldv);
      cycle();
      chk($sformatf("tbl%0d_ready", i), rdy_a_pre,    tbl[i].e_rdy);
      chk($sformatf("tbl%0d_valid", i), resp_valid_a, tbl[i].e_v);
      chk($sformatf("tbl%0d_data",  i), resp_data_a,  tbl[i].e_d);
      chk($sformatf("tbl%0d_err",   i), resp_err_a,   tbl[i].e_e);
      chk($sformatf("tbl%0d_cnt",   i), fetch_cnt_a,  tbl[i].e_c);
    end

    // Instance b (DEPTH 3): out-of-range fetch and ignored out-of-range load.
    drive(1, 3, 1, 1, 3, 'hFF);
    cycle();
    chk("oor_data_b", resp_data_b, 0);
    chk("oor_err_b",  resp_err_b,  1);
    drive(1, 0, 1, 0, 0, 0); cycle(); chk("oor_mem0_b", resp_data_b, 'h11);
    drive(1, 1, 1, 0, 0, 0); cycle(); chk("oor_mem1_b", resp_data_b, 'h22);
    drive(1, 2, 1, 0, 0, 0); cycle(); chk("oor_mem2_b", resp_data_b, 'hA5);
    chk("oor_err_clr_b", resp_err_b, 0);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 3), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 3), $urandom_range(0, 255));
      cycle();
    end

    // Asynchronous reset with a response pending.
    drive(1, 0, 1, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0); cycle();
    chk("pre_rst_valid", resp_valid_a, 1);
    reset = 1'b0;
    #1;
    chk("arst_valid_a", resp_valid_a, 0);
    chk("arst_cnt_a",   fetch_cnt_a,  0);
    chk("arst_data_a",  resp_data_a,  0);
    chk("arst_ready_a", req_ready_a,  0);
    chk("arst_valid_b", resp_valid_b, 0);
    chk("arst_cnt_b",   fetch_cnt_b,  0);
    m_rst = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    m_rst = 1'b1;
    drive(1, 0, 1, 0, 0, 0); cycle();
    chk("post_rst_mem0", resp_data_a, 0);
    chk("post_rst_v",    resp_valid_a, 1);
    drive(1, 3, 1, 0, 0, 0); cycle();
    chk("post_rst_mem3", resp_data_a, 0);

    // Counter wrap on instance b: 17 fetches from a fresh reset.
    reset = 1'b0;
    m_rst = 1'b0;
    model_clear();
    drive(0, 0, 1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1, i % 3, 1, 0, 0, 0);
      cycle();
    end
    chk("wrap_cnt_b", fetch_cnt_b, 1);
    chk("wrap_cnt_a", fetch_cnt_a, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
